clk_div_switch: RTL and testbench

- Parametrised successor of the two-source glitch-free CPLD clock switcher.
- Derives a switchable clock from one master clock, using a run-time selectable table of NDIV integer divisors, including a "stop" entry.
- Divisor changes take effect only at period boundaries, so the output never has a phase narrower than min(old, new) half-period. No runt pulses.
- Feeds the board clock-out pin and internal clock-enable consumers.

---
 rtl/clkdiv_pkg.sv | 25 ++
 rtl/sync_stages.sv | 30 +++
 rtl/clk_div_switch.sv | 120 ++++++++++++
 tb/tb_clk_div_switch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the glitch-free switchable clock divider.
package clkdiv_pkg;

   localparam int unsigned DefNdiv = 4;
   localparam int unsigned DefCw   = 8;

   // Entry i lives at bits [i*CW +: CW]; 0 stops the clock.
   localparam logic [DefNdiv*DefCw-1:0] DefDivs = {8'd0, 8'd5, 8'd3, 8'd2};

   typedef enum logic {
      StStop = 1'b0,
      StRun  = 1'b1
   } clkdiv_state_e;

   // A divide-by-1 cannot produce a clock with two phases, so it runs as divide-by-2.
   function automatic int unsigned eff_div(input int unsigned raw);
      return (raw == 1) ? 2 : raw;
   endfunction

   // High phase length: ceil(D/2) cycles; the low phase takes the remainder.
   function automatic int unsigned high_len(input int unsigned d);
      return (d + 1) / 2;
   endfunction

endpackage

// File: rtl/sync_stages.sv
// N-stage flop synchroniser, synchronous active-high reset to zero.
module sync_stages #(
   parameter int unsigned Stages = 2,
   parameter int unsigned Width  = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] stage_q [Stages];

   // Shift the input through the chain of stages.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < Stages; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < Stages; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/clk_div_switch.sv
// Glitch-free switchable clock divider. A new divisor is only taken at a period
// boundary, so no phase is ever shorter than the shorter of the old/new half-periods.
module clk_div_switch
   import clkdiv_pkg::*;
#(
   parameter int unsigned             NDIV = DefNdiv,
   parameter int unsigned             CW   = DefCw,
   parameter logic [NDIV*CW-1:0]      DIVS = DefDivs,
   parameter int unsigned             SYNC = 0,
   localparam int unsigned            SW   = (NDIV > 1) ? $clog2(NDIV) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [SW-1:0] sel_i,
   output logic          clkout_o,
   output logic          rise_o,
   output logic [SW-1:0] cur_sel_o,
   output logic          switching_o
);

   logic [SW-1:0] sel_s;

   if (SYNC > 0) begin : g_sync
      sync_stages #(
         .Stages(SYNC),
         .Width (SW)
      ) u_sync (
         .clk_i(clk_i),
         .rst_i(rst_i),
         .d_i  (sel_i),
         .q_o  (sel_s)
      );
   end else begin : g_nosync
      assign sel_s = sel_i;
   end

   clkdiv_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] d_act_q, d_act_d;
   logic [CW-1:0] h_act_q, h_act_d;
   logic [SW-1:0] cur_sel_q, cur_sel_d;
   logic          clkout_q, clkout_d;
   logic          rise_q, rise_d;

   logic [CW-1:0] div_raw;
   logic [CW-1:0] d_new;
   logic [CW-1:0] h_new;
   logic [CW-1:0] cnt_inc;
   logic          bnd;

   // Table lookup; an index beyond the table reads as stop.
   always_comb begin
      div_raw = '0;
      for (int unsigned i = 0; i < NDIV; i++) begin
         if (sel_s == SW'(i)) begin
            div_raw = DIVS[i*CW +: CW];
         end
      end
   end

   assign d_new   = CW'(eff_div(32'(div_raw)));
   assign h_new   = CW'(high_len(32'(d_new)));
   assign cnt_inc = cnt_q + CW'(1);
   assign bnd     = (state_q == StStop) || (cnt_q == d_act_q - CW'(1));

   // Next-state: reload at a period boundary, otherwise advance within the period.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      d_act_d   = d_act_q;
      h_act_d   = h_act_q;
      cur_sel_d = cur_sel_q;
      clkout_d  = clkout_q;
      rise_d    = 1'b0;
      if (bnd) begin
         cur_sel_d = sel_s;
         cnt_d     = '0;
         if (d_new != '0) begin
            d_act_d  = d_new;
            h_act_d  = h_new;
            clkout_d = 1'b1;
            rise_d   = 1'b1;
            state_d  = StRun;
         end else begin
            clkout_d = 1'b0;
            state_d  = StStop;
         end
      end else begin
         cnt_d    = cnt_inc;
         clkout_d = (cnt_inc < h_act_q);
      end
   end

   // State register; reset forces clkout low at once, even mid-phase.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StStop;
         cnt_q     <= '0;
         d_act_q   <= '0;
         h_act_q   <= '0;
         cur_sel_q <= '0;
         clkout_q  <= 1'b0;
         rise_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         d_act_q   <= d_act_d;
         h_act_q   <= h_act_d;
         cur_sel_q <= cur_sel_d;
         clkout_q  <= clkout_d;
         rise_q    <= rise_d;
      end
   end

   assign clkout_o    = clkout_q;
   assign rise_o      = rise_q;
   assign cur_sel_o   = cur_sel_q;
   assign switching_o = ~rst_i & (sel_s != cur_sel_q);

endmodule

// File: tb/tb_clk_div_switch.sv
// Randomised bench for clk_div_switch: two instances (no sync, 2-stage sync)
// compared every cycle against a phase-countdown reference model.
module tb_clk_div_switch;
   import clkdiv_pkg::*;

   logic       clk;
   logic       rst;
   logic [1:0] sel;

   logic       clkout0, rise0, sw0;
   logic [1:0] cur0;
   logic       clkout2, rise2, sw2;
   logic [1:0] cur2;

   clk_div_switch #(.SYNC(0)) u_dut0 (
      .clk_i      (clk),
      .rst_i      (rst),
      .sel_i      (sel),
      .clkout_o   (clkout0),
      .rise_o     (rise0),
      .cur_sel_o  (cur0),
      .switching_o(sw0)
   );

   clk_div_switch #(.SYNC(2)) u_dut2 (
      .clk_i      (clk),
      .rst_i      (rst),
      .sel_i      (sel),
      .clkout_o   (clkout2),
      .rise_o     (rise2),
      .cur_sel_o  (cur2),
      .switching_o(sw2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: at a boundary, load the period as H high cycles then L low
   // cycles, and count them down; an empty countdown is the next boundary.
   logic [31:0] divs = DefDivs;
   int hi_left [2];
   int lo_left [2];
   int e_clk   [2];
   int e_rise  [2];
   int e_cur   [2];
   int s1, s2;  // model of the 2-stage sel synchroniser

   function automatic int table_div(input int s);
      int raw;
      raw = int'(divs[s*8 +: 8]);
      return (raw == 1) ? 2 : raw;
   endfunction

   task automatic model_edge();
      int su, d, h;
      for (int m = 0; m < 2; m++) begin
         su = (m == 0) ? int'(sel) : s2;
         if (rst) begin
            hi_left[m] = 0; lo_left[m] = 0;
            e_clk[m] = 0; e_rise[m] = 0; e_cur[m] = 0;
         end else if (hi_left[m] == 0 && lo_left[m] == 0) begin
            d = table_div(su);
            e_cur[m] = su;
            e_rise[m] = 0;
            e_clk[m] = 0;
            if (d != 0) begin
               h = int'(high_len(d));
               hi_left[m] = h - 1;
               lo_left[m] = d - h;
               e_clk[m] = 1;
               e_rise[m] = 1;
            end
         end else begin
            e_rise[m] = 0;
            if (hi_left[m] > 0) begin
               hi_left[m]--; e_clk[m] = 1;
            end else begin
               lo_left[m]--; e_clk[m] = 0;
            end
         end
      end
      if (rst) begin
         s1 = 0; s2 = 0;
      end else begin
         s2 = s1; s1 = int'(sel);
      end
   endtask

   task automatic check_all();
      check("clkout0", int'(clkout0), e_clk[0]);
      check("rise0", int'(rise0), e_rise[0]);
      check("cur_sel0", int'(cur0), e_cur[0]);
      check("switching0", int'(sw0), rst ? 0 : int'(int'(sel) != e_cur[0]));
      check("clkout2", int'(clkout2), e_clk[1]);
      check("rise2", int'(rise2), e_rise[1]);
      check("cur_sel2", int'(cur2), e_cur[1]);
      check("switching2", int'(sw2), rst ? 0 : int'(s2 != e_cur[1]));
   endtask

   // One clock: drive inputs, update the model on the edge, check on the falling edge.
   task automatic step(input logic r, input logic [1:0] s);
      rst = r;
      sel = s;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Phase-length monitor on clkout0; only runs whose start was seen are recorded.
   int mon_prev, mon_len, mon_valid, min_hi, min_lo;

   task automatic mon_reset();
      mon_prev = -1; mon_len = 0; mon_valid = 0; min_hi = 1000; min_lo = 1000;
   endtask

   task automatic mon_sample(input int v);
      if (v == mon_prev) begin
         mon_len++;
      end else begin
         if (mon_valid != 0) begin
            if (mon_prev == 1 && mon_len < min_hi) min_hi = mon_len;
            if (mon_prev == 0 && mon_len < min_lo) min_lo = mon_len;
         end
         mon_valid = (mon_prev != -1) ? 1 : 0;
         mon_prev = v;
         mon_len = 1;
      end
   endtask

   // Advance with sel held until the model shows a period start (cnt=0 cycle).
   task automatic align_rise(input logic [1:0] s);
      int i;
      i = 0;
      while (i < 20 && e_rise[0] == 0) begin
         step(1'b0, s);
         i++;
      end
      check("align_rise", int'(rise0), 1);
   endtask

   int n_sw;

   initial begin
      rst = 1'b1;
      sel = 2'd0;
      s1 = 0; s2 = 0;
      for (int m = 0; m < 2; m++) begin
         hi_left[m] = 0; lo_left[m] = 0; e_clk[m] = 0; e_rise[m] = 0; e_cur[m] = 0;
      end

      // Reset, then D=2 from sel=0.
      for (int i = 0; i < 3; i++) step(1'b1, 2'd0);
      check("rst_clkout", int'(clkout0), 0);
      check("rst_rise", int'(rise0), 0);
      check("rst_cur", int'(cur0), 0);
      check("rst_switching", int'(sw0), 0);
      step(1'b0, 2'd0);
      check("first_high", int'(clkout0), 1);
      check("first_rise", int'(rise0), 1);
      for (int i = 0; i < 9; i++) step(1'b0, 2'd0);

      // D=3 steady state: min high 2, min low 1.
      for (int i = 0; i < 5; i++) step(1'b0, 2'd1);
      mon_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 2'd1);
         mon_sample(int'(clkout0));
      end
      check("min_high_d3", min_hi, 2);
      check("min_low_d3", min_lo, 1);

      // Switch 1->2 requested in the cnt=0 cycle of a D=3 period.
      align_rise(2'd1);
      n_sw = 0;
      sel = 2'd2;
      #1;
      if (sw0) n_sw++;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 2'd2);
         if (!sw0) break;
         n_sw++;
      end
      check("switch_len", n_sw, 3);
      for (int i = 0; i < 10; i++) step(1'b0, 2'd2);

      // Stop mid-period of D=5, then restart with D=2.
      align_rise(2'd2);
      step(1'b0, 2'd2);
      for (int i = 0; i < 12; i++) step(1'b0, 2'd3);
      check("stop_clkout", int'(clkout0), 0);
      check("stop_rise", int'(rise0), 0);
      check("stop_cur", int'(cur0), 3);
      step(1'b0, 2'd0);
      check("restart_high", int'(clkout0), 1);
      for (int i = 0; i < 6; i++) step(1'b0, 2'd2);

      // sel toggled 1->2->1 within one D=5 period.
      align_rise(2'd2);
      step(1'b0, 2'd1);
      step(1'b0, 2'd2);
      step(1'b0, 2'd1);
      step(1'b0, 2'd1);
      step(1'b0, 2'd1);
      check("toggle_cur", int'(cur0), 1);
      for (int i = 0; i < 6; i++) step(1'b0, 2'd2);

      // One-cycle reset in the high phase of D=5.
      align_rise(2'd2);
      step(1'b0, 2'd2);
      step(1'b1, 2'd2);
      check("midrst_clkout", int'(clkout0), 0);
      check("midrst_cur", int'(cur0), 0);
      step(1'b0, 2'd2);
      check("midrst_restart", int'(clkout0), 1);
      check("midrst_cur2", int'(cur0), 2);

      // Random soak: occasional sel changes and rare reset pulses.
      begin
         logic [1:0] rs;
         logic       rr;
         rs = 2'd0;
         for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0) rs = 2'($urandom_range(3));
            rr = ($urandom_range(499) == 0);
            step(rr, rs);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
